// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: single shared multiply/divide engine with HI/LO results.
// Runs a 32-iteration shift-add multiply or restoring divide per request.
//
// Ports:
//   clock, reset         rising-edge clock, synchronous active-high reset
//   start, op, a, b      request (op 0 = mult, 1 = div), sampled only in IDLE
//   busy                 high while RUN, FIX or DONE
//   done                 one-cycle completion pulse
//   div_zero             high with done when the divide had b == 0
//   hi_out, lo_out       HI (product high / remainder), LO (product low / quotient)
//
// Build option: define MULDIV_SIGNED_EN for two's complement operands;
// otherwise operands are treated as unsigned. Latency is the same either way.

module muldiv_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]  state;
    logic [5:0]  iterCount;
    logic        isDiv;
    logic        divZeroHit;
    // multiplicand for multiply, divisor for divide
    logic [31:0] operand;
    // multiply: {partial product, remaining multiplier}
    // divide:   {remainder, quotient}
    logic [63:0] acc;
    logic [31:0] hiReg;
    logic [31:0] loReg;

    logic [31:0] magA;
    logic [31:0] magB;
    logic [32:0] addSum;
    logic [63:0] accShl;
    logic [32:0] trialRem;
    logic [32:0] trialDiff;
    logic [63:0] accNext;
    logic [63:0] prodFinal;
    logic [31:0] quoFinal;
    logic [31:0] remFinal;
    logic [31:0] hiStage;
    logic [31:0] loStage;

`ifdef MULDIV_SIGNED_EN
    logic signA;
    logic signB;
    logic negResult;

    // |-2^31| = 0x80000000 is still exact as an unsigned magnitude
    assign magA = a[31] ? (~a + 32'd1) : a;
    assign magB = b[31] ? (~b + 32'd1) : b;
`else
    assign magA = a;
    assign magB = b;
`endif

    // One iteration of either algorithm, selected by the latched op.
    always_comb begin
        addSum    = {1'b0, acc[63:32]}
                  + (acc[0] ? {1'b0, operand} : 33'd0);
        accShl    = {acc[62:0], 1'b0};
        // keep the bit shifted out of rem: the shifted rem can exceed 32 bits
        trialRem  = {acc[63], accShl[63:32]};
        trialDiff = trialRem - {1'b0, operand};
        if (isDiv) begin
            if (trialDiff[32]) begin
                accNext = accShl;
            end else begin
                accNext = {trialDiff[31:0], accShl[31:1], 1'b1};
            end
        end else begin
            accNext = {addSum, acc[31:1]};
        end
    end

    // Final HI/LO values, staged for the FIX -> DONE edge.
    always_comb begin
`ifdef MULDIV_SIGNED_EN
        negResult = signA ^ signB;
        prodFinal = negResult ? (~acc + 64'd1) : acc;
        quoFinal  = negResult ? (~acc[31:0] + 32'd1) : acc[31:0];
        remFinal  = signA ? (~acc[63:32] + 32'd1) : acc[63:32];
`else
        prodFinal = acc;
        quoFinal  = acc[31:0];
        remFinal  = acc[63:32];
`endif
        if (isDiv) begin
            hiStage = remFinal;
            loStage = quoFinal;
        end else begin
            hiStage = prodFinal[63:32];
            loStage = prodFinal[31:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            iterCount  <= 6'd0;
            isDiv      <= 1'b0;
            divZeroHit <= 1'b0;
            operand    <= 32'd0;
            acc        <= 64'd0;
            hiReg      <= 32'd0;
            loReg      <= 32'd0;
`ifdef MULDIV_SIGNED_EN
            signA      <= 1'b0;
            signB      <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (op && (b == 32'd0)) begin
                            // HI/LO are left untouched on this path
                            divZeroHit <= 1'b1;
                            state      <= DONE;
                        end else begin
                            isDiv      <= op;
                            divZeroHit <= 1'b0;
                            iterCount  <= 6'd0;
                            operand    <= op ? magB : magA;
                            acc        <= op ? {32'd0, magA}
                                             : {32'd0, magB};
`ifdef MULDIV_SIGNED_EN
                            signA      <= a[31];
                            signB      <= b[31];
`endif
                            state      <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc       <= accNext;
                    iterCount <= iterCount + 6'd1;
                    if (iterCount == 6'd31) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    hiReg <= hiStage;
                    loReg <= loStage;
                    state <= DONE;
                end
                DONE: begin
                    divZeroHit <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign div_zero = (state == DONE) && divZeroHit;
    assign hi_out   = hiReg;
    assign lo_out   = loReg;

endmodule
